// File: rtl/intel_8080_pkg.sv
// Shared constants for the 8080-style host bus receiver.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package intel_8080_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WR_LOW = 2'd1;
  localparam logic [1:0] ST_RD_LOW = 2'd2;

  // Status word layout returned on host reads
  localparam int STAT_OVF     = 15;
  localparam int STAT_LVL_LSB = 0;
  localparam int STAT_LVL_W   = 8;

  // Dropped-write counter width
  localparam int DROP_W = 16;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/intel_8080_rx_fifo.sv
// Synchronous show-ahead FIFO holding captured {dc, data} words.
// Latency: push visible at head_dat/!empty one cycle later; pop takes effect on the same edge.
// Backpressure: push while full is refused unless a pop happens in the same cycle.
// Ports: clk/rst (sync, active-high); push/push_dat write side; pop read side;
//        head_dat = current head word (zero when empty); full/empty/level status.
module intel_8080_rx_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign level = cnt_q;

  // A pop frees a slot on the same edge, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Gate the head so stale storage never leaks out while empty.
  assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/intel_8080_slave_rx.sv
// Receives 8080-style host write cycles into a FIFO as {dc, data}; answers reads with status.
// Latency: WR rising at the pin -> m_valid after SYNC_STAGES+2 sys_clk cycles (empty FIFO).
// Backpressure: m_valid/m_ready; host writes arriving while the FIFO is full are dropped and counted.
// Ports: sys_clk/sys_rst (sync, active-high); bus_* host pins (async, strobes active-low);
//        bus_DATA_o/bus_DATA_oe status drive during reads; m_valid/m_data/m_ready stream out;
//        ovf/drop_cnt sticky overflow info, cleared by clr_ovf.
module intel_8080_slave_rx
  import intel_8080_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              bus_CS,
  input  logic              bus_DC,
  input  logic              bus_WR,
  input  logic              bus_RD,
  input  logic [DATA_W-1:0] bus_DATA_i,
  output logic [DATA_W-1:0] bus_DATA_o,
  output logic              bus_DATA_oe,
  output logic              m_valid,
  output logic [DATA_W:0]   m_data,
  input  logic              m_ready,
  output logic              ovf,
  output logic [DROP_W-1:0] drop_cnt,
  input  logic              clr_ovf
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // Synchronisers: strobe chains idle high so reset never fakes a strobe.
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
  logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
  logic [SYNC_STAGES-1:0] dc_sync_q, dc_sync_d;
  logic [DATA_W-1:0]      data_sync_q [SYNC_STAGES];
  logic [DATA_W-1:0]      data_sync_d [SYNC_STAGES];
  logic                   cs_s, wr_s, rd_s, dc_s;
  logic [DATA_W-1:0]      data_s;

  logic [1:0]        state_q, state_d;
  logic [DATA_W:0]   shadow_q, shadow_d;
  logic              push_q, push_d;
  logic [DATA_W:0]   push_dat_q, push_dat_d;
  logic              oe_q, oe_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic              fifo_full, fifo_empty, pop, drop;
  logic [LVL_W-1:0]  fifo_level;
  logic [DATA_W-1:0] status;

  always_comb begin
    cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], bus_CS};
    wr_sync_d = {wr_sync_q[SYNC_STAGES-2:0], bus_WR};
    rd_sync_d = {rd_sync_q[SYNC_STAGES-2:0], bus_RD};
    dc_sync_d = {dc_sync_q[SYNC_STAGES-2:0], bus_DC};
    data_sync_d[0] = bus_DATA_i;
    for (int i = 1; i < SYNC_STAGES; i++) data_sync_d[i] = data_sync_q[i-1];
  end

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign wr_s   = wr_sync_q[SYNC_STAGES-1];
  assign rd_s   = rd_sync_q[SYNC_STAGES-1];
  assign dc_s   = dc_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  always_comb begin
    status = '0;
    status[STAT_OVF] = ovf_q;
    status[STAT_LVL_LSB +: STAT_LVL_W] = STAT_LVL_W'(fifo_level);
  end

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    push_d     = 1'b0;
    push_dat_d = push_dat_q;
    oe_d       = oe_q;
    dout_d     = dout_q;
    case (state_q)
      ST_IDLE: begin
        // Write wins when both strobes are low.
        if (!cs_s && !wr_s) begin
          state_d = ST_WR_LOW;
        end else if (!cs_s && !rd_s) begin
          state_d = ST_RD_LOW;
          oe_d    = 1'b1;
          dout_d  = status;
        end
      end
      ST_WR_LOW: begin
        // shadow_q holds the bus as it was the cycle before WR was seen high.
        shadow_d = {dc_s, data_s};
        if (wr_s) begin
          push_d     = 1'b1;
          push_dat_d = shadow_q;
          state_d    = ST_IDLE;
        end else if (cs_s) begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_LOW: begin
        if (rd_s || cs_s) begin
          oe_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        oe_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // A drop is a registered push that the FIFO cannot take this cycle.
  assign pop  = m_valid && m_ready;
  assign drop = push_q && fifo_full && !pop;

  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      ovf_d      = 1'b1;
      drop_cnt_d = clr_ovf ? DROP_W'(1) : sat_inc(drop_cnt_q);
    end else if (clr_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cs_sync_q  <= '1;
      wr_sync_q  <= '1;
      rd_sync_q  <= '1;
      dc_sync_q  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
      state_q    <= ST_IDLE;
      shadow_q   <= '0;
      push_q     <= 1'b0;
      push_dat_q <= '0;
      oe_q       <= 1'b0;
      dout_q     <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      cs_sync_q  <= cs_sync_d;
      wr_sync_q  <= wr_sync_d;
      rd_sync_q  <= rd_sync_d;
      dc_sync_q  <= dc_sync_d;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_d[i];
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      push_q     <= push_d;
      push_dat_q <= push_dat_d;
      oe_q       <= oe_d;
      dout_q     <= dout_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  intel_8080_rx_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .push     (push_q),
    .push_dat (push_dat_q),
    .pop      (pop),
    .head_dat (m_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign m_valid     = !fifo_empty;
  assign bus_DATA_o  = dout_q;
  assign bus_DATA_oe = oe_q;
  assign ovf         = ovf_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_intel_8080_slave_rx.sv
// Directed bench for intel_8080_slave_rx: host write/read cycles, overflow, abort, reset.
// Latency: n/a.
// Backpressure: m_ready driven explicitly per step.
module tb_intel_8080_slave_rx;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        bus_CS, bus_DC, bus_WR, bus_RD;
  logic [15:0] bus_DATA_i;
  logic [15:0] bus_DATA_o;
  logic        bus_DATA_oe;
  logic        m_valid;
  logic [16:0] m_data;
  logic        m_ready;
  logic        ovf;
  logic [15:0] drop_cnt;
  logic        clr_ovf;

  int checks = 0;
  int errors = 0;

  always #10 sys_clk = ~sys_clk;

  intel_8080_slave_rx #(
    .DATA_W      (16),
    .FIFO_DEPTH  (16),
    .SYNC_STAGES (2)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .bus_CS      (bus_CS),
    .bus_DC      (bus_DC),
    .bus_WR      (bus_WR),
    .bus_RD      (bus_RD),
    .bus_DATA_i  (bus_DATA_i),
    .bus_DATA_o  (bus_DATA_o),
    .bus_DATA_oe (bus_DATA_oe),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .ovf         (ovf),
    .drop_cnt    (drop_cnt),
    .clr_ovf     (clr_ovf)
  );

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full host write cycle; leaves enough idle time for the word to land in the FIFO.
  task automatic host_write(input logic dc, input logic [15:0] dat);
    bus_CS = 1'b0; bus_DC = dc; bus_DATA_i = dat;
    tick(1);
    bus_WR = 1'b0;
    tick(5);
    bus_WR = 1'b1;
    tick(1);
    bus_CS = 1'b1;
    tick(4);
  endtask

  // Host status read; checks oe rise, value, and oe release within SYNC_STAGES+1 cycles.
  task automatic host_read(input string tag, input logic [15:0] exp);
    bus_CS = 1'b0; bus_RD = 1'b0;
    tick(5);
    check({tag, "_oe_hi"}, 32'(bus_DATA_oe), 32'd1);
    check({tag, "_stat"},  32'(bus_DATA_o),  32'(exp));
    bus_RD = 1'b1;
    tick(3);
    check({tag, "_oe_lo"}, 32'(bus_DATA_oe), 32'd0);
    check({tag, "_hold"},  32'(bus_DATA_o),  32'(exp));
    bus_CS = 1'b1;
    tick(2);
  endtask

  initial begin
    sys_rst = 1'b1; bus_CS = 1'b1; bus_DC = 1'b0; bus_WR = 1'b1; bus_RD = 1'b1;
    bus_DATA_i = '0; m_ready = 1'b0; clr_ovf = 1'b0;
    tick(3);
    sys_rst = 1'b0;
    tick(1);

    // Reset state
    check("rst_m_valid", 32'(m_valid),     32'd0);
    check("rst_m_data",  32'(m_data),      32'd0);
    check("rst_oe",      32'(bus_DATA_oe), 32'd0);
    check("rst_dout",    32'(bus_DATA_o),  32'd0);
    check("rst_ovf",     32'(ovf),         32'd0);
    check("rst_drop",    32'(drop_cnt),    32'd0);

    // Single write with latency check: valid exactly 4 edges after WR rises
    bus_CS = 1'b0; bus_DC = 1'b1; bus_DATA_i = 16'hA5C3;
    tick(1);
    bus_WR = 1'b0;
    tick(5);
    bus_WR = 1'b1;
    tick(3);
    check("lat_not_yet", 32'(m_valid), 32'd0);
    tick(1);
    check("lat_valid",   32'(m_valid), 32'd1);
    check("single_data", 32'(m_data),  32'h1A5C3);
    bus_CS = 1'b1;
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    check("single_popped", 32'(m_valid), 32'd0);
    tick(2);

    // Command then data, held back, then status read of level 3
    host_write(1'b0, 16'h002C);
    host_write(1'b1, 16'h1234);
    host_write(1'b1, 16'h5678);
    host_read("lvl3", 16'h0003);
    check("cmd_head", 32'(m_data), 32'h0002C);
    m_ready = 1'b1;
    tick(1);
    check("data1", 32'(m_data), 32'h11234);
    tick(1);
    check("data2", 32'(m_data), 32'h15678);
    tick(1);
    m_ready = 1'b0;
    check("drained", 32'(m_valid), 32'd0);

    // Overflow: 18 writes into a 16-deep FIFO
    for (int i = 0; i < 18; i++) host_write(1'b1, 16'h0100 + 16'(i));
    check("ovf_set",  32'(ovf),      32'd1);
    check("ovf_drop", 32'(drop_cnt), 32'd2);
    host_read("ovf", 16'h8010);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    check("clr_ovf",  32'(ovf),      32'd0);
    check("clr_drop", 32'(drop_cnt), 32'd0);
    host_read("post_clr", 16'h0010);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovf_word%0d", i), 32'(m_data), 32'h10100 + 32'(i));
      m_ready = 1'b1;
      tick(1);
    end
    m_ready = 1'b0;
    check("ovf_drained", 32'(m_valid), 32'd0);

    // CS abort: CS raised while WR still low
    bus_CS = 1'b0; bus_DC = 1'b1; bus_DATA_i = 16'hDEAD;
    tick(1);
    bus_WR = 1'b0;
    tick(5);
    bus_CS = 1'b1;
    tick(3);
    bus_WR = 1'b1;
    tick(6);
    check("abort_no_push", 32'(m_valid), 32'd0);

    // WR and RD low together: treated as a write, no read drive
    bus_CS = 1'b0; bus_DC = 1'b1; bus_DATA_i = 16'hBEEF;
    tick(1);
    bus_WR = 1'b0; bus_RD = 1'b0;
    tick(5);
    check("wr_rd_oe", 32'(bus_DATA_oe), 32'd0);
    bus_WR = 1'b1; bus_RD = 1'b1;
    tick(1);
    bus_CS = 1'b1;
    tick(4);
    check("wr_rd_valid", 32'(m_valid),     32'd1);
    check("wr_rd_data",  32'(m_data),      32'h1BEEF);
    check("wr_rd_oe2",   32'(bus_DATA_oe), 32'd0);
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;

    // Reset during WR_LOW with two words buffered
    host_write(1'b1, 16'h1111);
    host_write(1'b1, 16'h2222);
    check("pre_rst_data", 32'(m_data), 32'h11111);
    bus_CS = 1'b0; bus_DATA_i = 16'h3333;
    tick(1);
    bus_WR = 1'b0;
    tick(5);
    sys_rst = 1'b1;
    tick(1);
    sys_rst = 1'b0; bus_WR = 1'b1; bus_CS = 1'b1;
    tick(6);
    check("rst_mid_valid", 32'(m_valid),     32'd0);
    check("rst_mid_ovf",   32'(ovf),         32'd0);
    check("rst_mid_oe",    32'(bus_DATA_oe), 32'd0);
    host_read("rst_mid", 16'h0000);
    check("rst_mid_valid2", 32'(m_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
